// File: rtl/softmax_pkg.sv
// Shared state encoding, FP constants and scalar IEEE-754 single-precision helpers
// (round-to-nearest-even, subnormals flushed to signed zero) for the softmax backward block.
package softmax_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DOT_MUL = 3'd1,
    DOT_ADD = 3'd2,
    EL_SUB  = 3'd3,
    EL_MUL  = 3'd4
  } state_t;

  localparam logic [31:0] FP_ZERO     = 32'h00000000;
  localparam logic [31:0] FP_ONE      = 32'h3F800000;
  localparam int          FP_SIGN_BIT = 31;
  localparam logic [31:0] FP_QNAN     = 32'h7FC00000;
  localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;

  function automatic logic [4:0] clz27(input logic [26:0] v);
    logic [4:0] c;
    logic       found;
    c     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) found = 1'b1;
      else if (!found)    c = c + 5'd1;
      else                c = c;
    end
    return c;
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic               sr, guard, sticky, rnd, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0]        prod;
    logic [22:0]        mant;
    logic [23:0]        mr;
    logic signed [9:0]  er;
    logic [31:0]        r;
    sr     = a[FP_SIGN_BIT] ^ b[FP_SIGN_BIT];
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == FP_EXP_MAX) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == FP_EXP_MAX) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == FP_EXP_MAX) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == FP_EXP_MAX) && (b[22:0] != 23'd0);
    prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    er     = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      er     = er + 10'sd1;
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    rnd = guard & (sticky | mant[0]);
    mr  = {1'b0, mant} + {23'd0, rnd};
    if (mr[23]) er = er + 10'sd1;
    else        er = er;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) r = FP_QNAN;
    else if (a_inf || b_inf)   r = {sr, FP_EXP_MAX, 23'd0};
    else if (a_zero || b_zero) r = {sr, 31'd0};
    else if (er >= 10'sd255)   r = {sr, FP_EXP_MAX, 23'd0};
    else if (er <= 10'sd0)     r = {sr, 31'd0};
    else                       r = {sr, er[7:0], mr[22:0]};
    return r;
  endfunction

  // Operands are swapped so x has the larger magnitude; y is aligned with a sticky bit.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, cancel, rnd;
    logic [31:0]        x, y, r;
    logic [26:0]        mx, my, msh, n;
    logic [27:0]        sum;
    logic [7:0]         d;
    logic [4:0]         lz;
    logic [23:0]        mr;
    logic signed [9:0]  er;
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == FP_EXP_MAX) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == FP_EXP_MAX) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == FP_EXP_MAX) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == FP_EXP_MAX) && (b[22:0] != 23'd0);
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    d  = x[30:23] - y[30:23];
    if (d >= 8'd27) begin
      msh = 27'd1;
    end else begin
      msh    = my >> d;
      msh[0] = msh[0] | ((my & ~(27'h7FFFFFF << d)) != 27'd0);
    end
    er     = $signed({2'b00, x[30:23]});
    lz     = 5'd0;
    cancel = 1'b0;
    if (x[FP_SIGN_BIT] == y[FP_SIGN_BIT]) begin
      sum = {1'b0, mx} + {1'b0, msh};
      if (sum[27]) begin
        n  = {sum[27:2], sum[1] | sum[0]};
        er = er + 10'sd1;
      end else begin
        n  = sum[26:0];
      end
    end else begin
      sum    = {1'b0, mx} - {1'b0, msh};
      cancel = (sum == 28'd0);
      lz     = clz27(sum[26:0]);
      n      = sum[26:0] << lz;
      er     = er - $signed({5'd0, lz});
    end
    rnd = n[2] & (n[1] | n[0] | n[3]);
    mr  = {1'b0, n[25:3]} + {23'd0, rnd};
    if (mr[23]) er = er + 10'sd1;
    else        er = er;
    if (a_nan || b_nan || (a_inf && b_inf && (a[FP_SIGN_BIT] != b[FP_SIGN_BIT]))) r = FP_QNAN;
    else if (a_inf)            r = a;
    else if (b_inf)            r = b;
    else if (a_zero && b_zero) r = {a[FP_SIGN_BIT] & b[FP_SIGN_BIT], 31'd0};
    else if (a_zero)           r = b;
    else if (b_zero)           r = a;
    else if (cancel)           r = FP_ZERO;
    else if (er <= 10'sd0)     r = {x[FP_SIGN_BIT], 31'd0};
    else if (er >= 10'sd255)   r = {x[FP_SIGN_BIT], FP_EXP_MAX, 23'd0};
    else                       r = {x[FP_SIGN_BIT], er[7:0], mr[22:0]};
    return r;
  endfunction

endpackage

// File: rtl/single_fp_seq_unit.sv
// One scalar FP multiplier and one scalar FP adder/subtractor; each takes an issue pulse,
// counts down its latency and raises a one-cycle result_valid with the held result.
module single_fp_seq_unit
  import softmax_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int ADD_LAT = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mul_issue,
  input  logic [31:0] mul_a,
  input  logic [31:0] mul_b,
  input  logic        add_issue,
  input  logic        add_sub,
  input  logic [31:0] add_a,
  input  logic [31:0] add_b,
  output logic        mul_valid,
  output logic [31:0] mul_result,
  output logic        add_valid,
  output logic [31:0] add_result
);

  localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT + 1) : 1;
  localparam int ACW = (ADD_LAT > 1) ? $clog2(ADD_LAT + 1) : 1;

  logic [MCW-1:0] mul_cnt;
  logic [ACW-1:0] add_cnt;

  // Multiplier: result computed at issue, released after MUL_LAT cycles
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mul_cnt    <= MCW'(0);
      mul_valid  <= 1'b0;
      mul_result <= FP_ZERO;
    end else if (mul_issue) begin
      mul_result <= fp_mul(mul_a, mul_b);
      mul_cnt    <= MCW'(MUL_LAT - 1);
      mul_valid  <= (MUL_LAT == 1);
    end else if (mul_cnt != MCW'(0)) begin
      mul_cnt    <= mul_cnt - MCW'(1);
      mul_valid  <= (mul_cnt == MCW'(1));
    end else begin
      mul_valid  <= 1'b0;
    end
  end

  // Adder: add_sub flips the sign of b so subtraction is a plain add
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      add_cnt    <= ACW'(0);
      add_valid  <= 1'b0;
      add_result <= FP_ZERO;
    end else if (add_issue) begin
      add_result <= fp_add(add_a, {add_b[FP_SIGN_BIT] ^ add_sub, add_b[30:0]});
      add_cnt    <= ACW'(ADD_LAT - 1);
      add_valid  <= (ADD_LAT == 1);
    end else if (add_cnt != ACW'(0)) begin
      add_cnt    <= add_cnt - ACW'(1);
      add_valid  <= (add_cnt == ACW'(1));
    end else begin
      add_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/single_softmax_bwd_v.sv
// Serial softmax backward pass dx[i] = y[i]*(dy[i] - sum_j y[j]*dy[j]) on one FP mul + one FP add.
// Optional build macro SOFTMAX_BWD_DOT_OUT_EN adds the 'dot' output carrying the final sum.
module single_softmax_bwd_v
  import softmax_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 3,
  parameter int ADD_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [WIDTH-1:0][31:0] vector_y,
  input  logic [WIDTH-1:0][31:0] vector_dy,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0][31:0] vector_dx
`ifdef SOFTMAX_BWD_DOT_OUT_EN
  ,
  output logic [31:0]            dot
`endif
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t                 state, state_nx;
  logic [IW-1:0]          idx, idx_inc;
  logic                   last, first_r;
  logic [31:0]            acc;
  logic [WIDTH-1:0][31:0] y_r, dy_r, dx_work;

  logic        mul_issue, add_issue, add_sub, mul_valid, add_valid;
  logic [31:0] mul_a, mul_b, add_a, add_b, mul_result, add_result;

  assign last    = (idx == IW'(WIDTH - 1));
  assign idx_inc = idx + IW'(1);

  single_fp_seq_unit #(
    .MUL_LAT(MUL_LAT),
    .ADD_LAT(ADD_LAT)
  ) u_fp (
    .clk       (clk),
    .rstn      (rstn),
    .mul_issue (mul_issue),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .add_issue (add_issue),
    .add_sub   (add_sub),
    .add_a     (add_a),
    .add_b     (add_b),
    .mul_valid (mul_valid),
    .mul_result(mul_result),
    .add_valid (add_valid),
    .add_result(add_result)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: each phase ends on the result_valid of the unit it waits on
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)     state_nx = DOT_MUL;
               else           state_nx = IDLE;
      DOT_MUL: if (mul_valid) state_nx = DOT_ADD;
               else           state_nx = DOT_MUL;
      DOT_ADD: if (add_valid) state_nx = last ? EL_SUB : DOT_MUL;
               else           state_nx = DOT_ADD;
      EL_SUB:  if (add_valid) state_nx = EL_MUL;
               else           state_nx = EL_SUB;
      EL_MUL:  if (mul_valid) state_nx = last ? IDLE : EL_SUB;
               else           state_nx = EL_MUL;
      default:                state_nx = IDLE;
    endcase
  end

  // Issue logic: the next operation launches on the same edge that ends the current phase,
  // using bypassed unit results so no cycle is lost per phase.
  always_comb begin
    mul_issue = 1'b0;
    mul_a     = FP_ZERO;
    mul_b     = FP_ZERO;
    add_issue = 1'b0;
    add_sub   = 1'b0;
    add_a     = FP_ZERO;
    add_b     = FP_ZERO;
    case (state)
      DOT_MUL: begin
        if (first_r) begin
          mul_issue = 1'b1;
          mul_a     = y_r[idx];
          mul_b     = dy_r[idx];
        end else if (mul_valid) begin
          add_issue = 1'b1;
          add_a     = acc;
          add_b     = mul_result;
        end else begin
          add_issue = 1'b0;
        end
      end
      DOT_ADD: begin
        if (add_valid && last) begin
          add_issue = 1'b1;
          add_sub   = 1'b1;
          add_a     = dy_r[0];
          add_b     = add_result;
        end else if (add_valid) begin
          mul_issue = 1'b1;
          mul_a     = y_r[idx_inc];
          mul_b     = dy_r[idx_inc];
        end else begin
          mul_issue = 1'b0;
        end
      end
      EL_SUB: begin
        if (add_valid) begin
          mul_issue = 1'b1;
          mul_a     = y_r[idx];
          mul_b     = add_result;
        end else begin
          mul_issue = 1'b0;
        end
      end
      EL_MUL: begin
        if (mul_valid && !last) begin
          add_issue = 1'b1;
          add_sub   = 1'b1;
          add_a     = dy_r[idx_inc];
          add_b     = acc;
        end else begin
          add_issue = 1'b0;
        end
      end
      default: begin
        mul_issue = 1'b0;
        add_issue = 1'b0;
      end
    endcase
  end

  // Datapath registers and outputs; vector_dx is published only as a whole on done
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx       <= IW'(0);
      first_r   <= 1'b0;
      acc       <= FP_ZERO;
      y_r       <= {WIDTH{FP_ZERO}};
      dy_r      <= {WIDTH{FP_ZERO}};
      dx_work   <= {WIDTH{FP_ZERO}};
      vector_dx <= {WIDTH{FP_ZERO}};
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SOFTMAX_BWD_DOT_OUT_EN
      dot       <= FP_ZERO;
`endif
    end else begin
      done    <= 1'b0;
      first_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            y_r     <= vector_y;
            dy_r    <= vector_dy;
            acc     <= FP_ZERO;
            idx     <= IW'(0);
            first_r <= 1'b1;
            busy    <= 1'b1;
          end
        end
        DOT_ADD: begin
          if (add_valid) begin
            acc <= add_result;
            idx <= last ? IW'(0) : idx_inc;
          end
        end
        EL_MUL: begin
          if (mul_valid) begin
            dx_work[idx] <= mul_result;
            if (last) begin
              for (int i = 0; i < WIDTH; i++)
                vector_dx[i] <= (IW'(i) == idx) ? mul_result : dx_work[i];
              done <= 1'b1;
              busy <= 1'b0;
              idx  <= IW'(0);
`ifdef SOFTMAX_BWD_DOT_OUT_EN
              dot  <= acc;
`endif
            end else begin
              idx <= idx_inc;
            end
          end
        end
        default: begin
          idx <= idx;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_single_softmax_bwd_v.sv
// Self-checking bench for single_softmax_bwd_v (WIDTH=4, MUL_LAT=3, ADD_LAT=3): directed table,
// randomized dyadic vectors against an exact integer model, and start/reset corner sequences.
module tb_single_softmax_bwd_v;

  localparam int W   = 4;
  localparam int LAT = 1 + 2 * W * (3 + 3);

  typedef struct {
    logic [W-1:0][31:0] y;
    logic [W-1:0][31:0] dy;
    logic [W-1:0][31:0] dx;
    logic [31:0]        dot;
  } vec_t;

  logic               clk, rstn, start, busy, done;
  logic [W-1:0][31:0] vector_y, vector_dy, vector_dx;
  logic [31:0]        dot;
  int                 n_total, n_pass;

  single_softmax_bwd_v #(.WIDTH(W), .MUL_LAT(3), .ADD_LAT(3)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .vector_y (vector_y),
    .vector_dy(vector_dy),
    .busy     (busy),
    .done     (done),
    .vector_dx(vector_dx)
`ifdef SOFTMAX_BWD_DOT_OUT_EN
    ,
    .dot      (dot)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Exact value v * 2^-fb as a single; zero carries the requested sign.
  function automatic logic [31:0] to_fp(input int v, input int fb, input bit neg_zero);
    int          m, p;
    logic [31:0] t;
    if (v == 0) return neg_zero ? 32'h80000000 : 32'h00000000;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 31; i++) if (m[i]) p = i;
    t = 32'(m) << (23 - p);
    return {v < 0, 8'(p - fb + 127), t[22:0]};
  endfunction

  // y = a/16 (a>=0), dy = b/16; s = S/256; dx = a*(16b-S)/4096, all exact in single.
  task automatic gen_random(output vec_t v);
    int a[W], b[W], s, d;
    s = 0;
    for (int i = 0; i < W; i++) begin
      a[i] = int'($urandom_range(16, 0));
      b[i] = int'($urandom_range(32, 0)) - 16;
      s += a[i] * b[i];
    end
    for (int i = 0; i < W; i++) begin
      d        = 16 * b[i] - s;
      v.y[i]   = to_fp(a[i], 4, 1'b0);
      v.dy[i]  = to_fp(b[i], 4, 1'b0);
      v.dx[i]  = to_fp(a[i] * d, 12, d < 0);
    end
    v.dot = to_fp(s, 8, 1'b0);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_check(input string tag, input vec_t v);
    int cyc;
    vector_y  = v.y;
    vector_dy = v.dy;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
    vector_y  = {$urandom, $urandom, $urandom, $urandom};
    vector_dy = {$urandom, $urandom, $urandom, $urandom};
    wait_done(cyc);
    chk({tag, " latency"}, 32'(cyc), 32'(LAT));
    chk({tag, " busy_in_done"}, 32'(busy), 32'd0);
    for (int i = 0; i < W; i++) chk($sformatf("%s dx%0d", tag, i), vector_dx[i], v.dx[i]);
`ifdef SOFTMAX_BWD_DOT_OUT_EN
    chk({tag, " dot"}, dot, v.dot);
`endif
    @(posedge clk); #1;
    chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, " dx_held"}, vector_dx[0], v.dx[0]);
  endtask

  vec_t tbl[3];
  vec_t rv;
  int   cyc, ndone;
  bit   busy_ok;

  initial begin
    n_total = 0;
    n_pass  = 0;
    rstn = 1'b0; start = 1'b0; vector_y = '0; vector_dy = '0;

    for (int i = 0; i < W; i++) begin
      tbl[0].y[i] = 32'h3E800000; tbl[0].dy[i] = 32'h3F800000; tbl[0].dx[i] = 32'h00000000;
      tbl[1].y[i] = 32'h00000000; tbl[1].dy[i] = 32'h00000000; tbl[1].dx[i] = 32'h80000000;
      tbl[2].y[i] = 32'h00000000; tbl[2].dy[i] = 32'h00000000; tbl[2].dx[i] = 32'h80000000;
    end
    tbl[0].dot   = 32'h3F800000;
    tbl[1].y[0]  = 32'h3F800000; tbl[1].dy[0] = 32'h40000000; tbl[1].dx[0] = 32'h00000000;
    tbl[1].dot   = 32'h40000000;
    tbl[2].y[0]  = 32'h3F000000; tbl[2].y[1]  = 32'h3F000000; tbl[2].dy[0] = 32'h3F800000;
    tbl[2].dx[0] = 32'h3E800000; tbl[2].dx[1] = 32'hBE800000;
    tbl[2].dot   = 32'h3F000000;

    repeat (2) @(posedge clk); #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    for (int i = 0; i < W; i++) chk($sformatf("reset dx%0d", i), vector_dx[i], 32'h0);
`ifdef SOFTMAX_BWD_DOT_OUT_EN
    chk("reset dot", dot, 32'h0);
`endif
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 3; t++) run_check($sformatf("dir%0d", t + 1), tbl[t]);

    for (int r = 0; r < 8; r++) begin
      gen_random(rv);
      run_check($sformatf("rand%0d", r), rv);
    end

    // Starts while busy are ignored; a start in the done cycle is accepted
    vector_y = tbl[0].y; vector_dy = tbl[0].dy; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; busy_ok = 1'b1; cyc = 0;
    while (!done && cyc < 200) begin
      start = (cyc == 5 || cyc == 30);
      @(posedge clk); #1;
      cyc++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    chk("ignore latency", 32'(cyc), 32'(LAT));
    chk("ignore busy_held", 32'(busy_ok), 32'd1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b busy", 32'(busy), 32'd1);
    chk("b2b done_dropped", 32'(done), 32'd0);
    wait_done(cyc);
    chk("b2b latency", 32'(cyc), 32'(LAT));
    for (int i = 0; i < W; i++) chk($sformatf("b2b dx%0d", i), vector_dx[i], 32'h0);
    ndone = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("no_queued_run", 32'(ndone), 32'd0);

    // Reset mid-run clears outputs immediately and suppresses done
    run_check("pre_reset", tbl[2]);
    vector_y = tbl[1].y; vector_dy = tbl[1].dy; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    for (int i = 0; i < W; i++) chk($sformatf("abort dx%0d", i), vector_dx[i], 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort no_done", 32'(ndone), 32'd0);
    run_check("after_reset", tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
